imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, instruction memory depth in 32-bit words; legal word counts 1..DEPTH.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  single-cycle request to begin a program load; honoured only in IDLE or ERR.
REQ-005 byte_valid  in  1  loader byte present on byte_data.
REQ-006 byte_data  in  8  loader stream byte.
REQ-007 byte_ready  out  1  block accepts byte_data this cycle; transfer occurs when byte_valid and byte_ready are both 1.
REQ-008 cpu_a  in  32  pipeline fetch address.
REQ-009 mem_a  out  32  address to instruction memory, byte address, word aligned.
REQ-010 mem_wd  out  32  write data to instruction memory.
REQ-011 mem_we  out  1  instruction memory write enable, one cycle per word.
REQ-012 cpu_hold  out  1  holds pipeline in reset/stall while loader owns memory.
REQ-013 done  out  1  one-cycle pulse: load completed successfully.
REQ-014 err  out  1  sticky error: word count 0 > DEPTH rule violated.

Function
REQ-015 States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR; state is a register, outputs decoded from registered state and counters.
REQ-016 Stream format: 2-byte little-endian word count N, then 4N bytes, each word little-endian (first byte -> bits 7:0).
REQ-017 IDLE: mem_a = cpu_a, mem_we = 0, cpu_hold = 0, byte_ready = 0; start -> LEN0 next cycle.
REQ-018 cpu_hold = 1 in every state except IDLE; mem_a never driven from cpu_a outside IDLE.
REQ-019 LEN0: byte_ready = 1; on transfer latch count[7:0], -> LEN1.
REQ-020 LEN1: byte_ready = 1; on transfer latch count[15:8]; if N = 0 -> DONE; if N > DEPTH -> ERR; else -> DATA with word_addr = 0, byte_idx = 0.
REQ-021 DATA: byte_ready = 1; each transfer stores byte at lane byte_idx, byte_idx increments mod 4; transfer at byte_idx = 3 -> WRITE.
REQ-022 byte_valid low in LEN0/LEN1/DATA: hold state, no counter change (arbitrary stall length).
REQ-023 WRITE: byte_ready = 0, mem_we = 1, mem_a = {word_addr, 2'b00}, mem_wd = assembled word; word_addr increments; if word_addr + 1 = N -> DONE else -> DATA.
REQ-024 DONE: done = 1 for exactly one cycle, -> IDLE.
REQ-025 ERR: err = 1, cpu_hold = 1, byte_ready = 0, no writes; start -> LEN0 and clears err; otherwise remain.
REQ-026 start in LEN0, LEN1, DATA, WRITE, DONE ignored.
REQ-027 Outside WRITE, mem_we = 0 and mem_wd = 0.
REQ-028 Latency, back-to-back bytes: start at cycle 0 -> LEN0 at 1, LEN1 at 2, first DATA at 3; each word 4 DATA + 1 WRITE cycles; done at cycle 3 + 5N.
REQ-029 word_addr width ceil(log2(DEPTH))+1; never wraps since N <= DEPTH.

Reset
REQ-030 reset_n low: state = IDLE, count = 0, word_addr = 0, byte_idx = 0, assembly register = 0, err = 0, done = 0, mem_we = 0, byte_ready = 0, cpu_hold = 0, mem_a = cpu_a.
REQ-031 Reset mid-load aborts immediately; words already written stay in memory; no further write occurs.

Verification
REQ-032 Idle pass-through: cpu_a = 0x0000_0010, no start -> mem_a = 0x0000_0010, cpu_hold = 0, mem_we = 0.
REQ-033 Load N = 2, bytes 02 00 13 05 A0 00 93 05 B0 00 back-to-back -> writes 0x00A00513 @0x0, 0x00B00593 @0x4; done pulse at cycle 13; cpu_hold returns 0 at cycle 14.
REQ-034 N = 65 (bytes 41 00), DEPTH = 64 -> ERR, err = 1, no mem_we, cpu_hold = 1; then start + N = 1 load -> err clears, single write, done.
REQ-035 N = 0 (bytes 00 00) -> DONE right after LEN1, no mem_we, done pulse one cycle.
REQ-036 byte_valid deasserted 3 cycles between byte 2 and byte 3 of a word -> identical written data, done delayed by 3 cycles.
REQ-037 reset_n low during DATA of word 1 of N = 3 -> word 0 written only, state IDLE, cpu_hold = 0, err = 0, no write after reset.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader for the instruction memory. A byte stream
//   carries a 2-byte little-endian word count N followed by 4N bytes (each
//   word little-endian). While loading, the loader owns the memory port
//   and holds the pipeline. When idle, the pipeline fetch address passes
//   straight through.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       one-cycle load request (honoured in IDLE or ERR)
//   byte_valid  stream byte present on byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts byte_data this cycle
//   cpu_a       pipeline fetch address
//   mem_a       instruction memory byte address
//   mem_wd      instruction memory write data
//   mem_we      instruction memory write enable
//   cpu_hold    pipeline hold while the loader owns memory
//   done        one-cycle pulse on successful completion
//   err         sticky: word count was 0 > DEPTH rule violation (N > DEPTH)
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] cpu_a,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int AW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [15:0]     count;
    logic [AW-1:0]   word_addr;
    logic [1:0]      byte_idx;
    logic [31:0]     asm_word;

    logic [15:0]     len_n;
    logic            last_word;

    // Full word count as it becomes known in LEN1 (high byte on the bus now).
    assign len_n     = {byte_data, count[7:0]};
    assign last_word = ((17'(word_addr) + 17'd1) == {1'b0, count});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        mem_a      = 32'({word_addr, 2'b00});
        cpu_hold   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                mem_a    = cpu_a;
                cpu_hold = 1'b0;
                if (start) next_state = LEN0;
            end
            LEN0: begin
                byte_ready = 1'b1;
                if (byte_valid) next_state = LEN1;
            end
            LEN1: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (len_n == 16'd0)                     next_state = DONE;
                    else if ({1'b0, len_n} > 17'(DEPTH))    next_state = ERR;
                    else                                    next_state = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_idx == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                mem_wd     = asm_word;
                next_state = last_word ? DONE : DATA;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                err = 1'b1;
                if (start) next_state = LEN0;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            word_addr <= '0;
            byte_idx  <= '0;
            asm_word  <= '0;
        end else begin
            case (state)
                LEN0: if (byte_valid) count[7:0] <= byte_data;
                LEN1: begin
                    if (byte_valid) begin
                        count[15:8] <= byte_data;
                        word_addr   <= '0;
                        byte_idx    <= '0;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        asm_word[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: word_addr <= word_addr + AW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader. Expected memory writes are queued as
//   {addr, data} when a word is driven and popped by a monitor when the DUT
//   asserts mem_we. Outputs are sampled on the falling edge; inputs change
//   1 time unit after the rising edge.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] cpu_a;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     = 0;

    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    imem_loader #(.DEPTH(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_a      (cpu_a),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we cycle must match the head of the queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: got addr %h data %h expected no write", mem_a, mem_wd);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", mem_a, mon_e[63:32]);
                chk("wr_data", mem_wd, mon_e[31:0]);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (byte_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL byte_timeout: got byte_ready %b expected 1 within 50 cycles", byte_ready);
        end else begin
            chk("hold_while_loading", 32'(cpu_hold), 32'd1);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int stall_after);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i == stall_after) idle(3);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL %s_done_timeout: got no done pulse expected one at cycle %0d", tag, exp_cyc);
        end else begin
            chk({tag, "_done_cycle"}, 32'(cyc - t0), 32'(exp_cyc));
            @(negedge clk);
            chk({tag, "_done_pulse_width"}, 32'(done), 32'd0);
            chk({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        cpu_a      = 32'h0000_0010;

        // Reset state
        #12;
        chk("rst_mem_a", mem_a, 32'h0000_0010);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Idle pass-through
        cpu_a = 32'h0000_0024;
        @(negedge clk);
        chk("idle_mem_a", mem_a, 32'h0000_0024);
        chk("idle_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        cpu_a = 32'h0000_0010;

        // N = 2 back-to-back
        exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
        exp_q.push_back({32'h0000_0004, 32'h00B0_0593});
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h00A0_0513, -1);
        send_word(32'h00B0_0593, -1);
        wait_done("n2", 13);

        // N = 65 exceeds DEPTH
        do_start();
        send_byte(8'h41);
        send_byte(8'h00);
        @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        chk("err_hold", 32'(cpu_hold), 32'd1);
        chk("err_byte_ready", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        idle(5);
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_no_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // Recovery from ERR with N = 1, one stall cycle in LEN0
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        do_start();
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        chk("recover_hold", 32'(cpu_hold), 32'd1);
        @(posedge clk);
        #1;
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hDEAD_BEEF, -1);
        wait_done("recover", 9);

        // N = 0
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done("n0", 3);

        // N = 2 with a 3-cycle stall between byte 2 and byte 3 of word 0
        exp_q.push_back({32'h0000_0000, 32'h00A0_0513});
        exp_q.push_back({32'h0000_0004, 32'h00B0_0593});
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h00A0_0513, 1);
        send_word(32'h00B0_0593, -1);
        wait_done("stall", 16);

        // Reset during DATA of word 1 of N = 3
        exp_q.push_back({32'h0000_0000, 32'h1122_3344});
        do_start();
        send_byte(8'h03);
        send_byte(8'h00);
        send_word(32'h1122_3344, -1);
        send_byte(8'h55);
        send_byte(8'h66);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_hold", 32'(cpu_hold), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_byte_ready", 32'(byte_ready), 32'd0);
        chk("abort_mem_a", mem_a, 32'h0000_0010);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(10);
        @(negedge clk);
        chk("post_abort_hold", 32'(cpu_hold), 32'd0);
        chk("post_abort_byte_ready", 32'(byte_ready), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
